// File: rtl/dplca_txop_table_ctrl.sv
// D-PLCA TXOP claim table: clear, max-claim/free-pick scan and CLAIMING lookup.
// Define DPLCA_TXOP_AGING_EN to build entries as 2-bit ages decremented on cycle_end.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for clear_req (priority) or scan_req
// ST_CLEAR| unclaiming entry idx each cycle, observations dropped
// ST_SCAN | examining entry idx each cycle, results latched on the last
module dplca_txop_table_ctrl #(
    parameter int TABLE_DEPTH = 256,
    parameter int AGE_MAX     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear_req,
    output logic       clear_done,
    input  logic       scan_req,
    output logic       scan_done,
    output logic       busy,
    input  logic       obs_valid,
    input  logic [7:0] obs_id,
    input  logic       cycle_end,
    input  logic [7:0] claiming_id,
    output logic       claiming,
    output logic [7:0] max_claim,
    output logic [7:0] free_txop,
    output logic       free_valid
);

    localparam int            IW       = $clog2(TABLE_DEPTH);
    localparam logic [8:0]    DEPTH9   = 9'(TABLE_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(TABLE_DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_SCAN} state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [TABLE_DEPTH-1:0] claimed_vec;
    logic                obs_hit;
    logic [IW-1:0]       obs_idx;
    logic                qry_hit;
    logic                cur_claimed;
    logic [7:0]          acc_max;
    logic [7:0]          acc_free;
    logic                acc_free_vld;
    logic [7:0]          nxt_max;
    logic [7:0]          nxt_free;
    logic                nxt_free_vld;
    logic                take_free;

    assign obs_hit     = obs_valid && ({1'b0, obs_id} < DEPTH9);
    assign obs_idx     = obs_id[IW-1:0];
    assign qry_hit     = {1'b0, claiming_id} < DEPTH9;
    assign cur_claimed = claimed_vec[idx];

`ifdef DPLCA_TXOP_AGING_EN
    localparam logic [1:0] AGE_LOAD = 2'(AGE_MAX);

    logic [1:0] age [TABLE_DEPTH];

    // A load in the same cycle as cycle_end takes precedence over the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) age[i] <= 2'd0;
        end else if (state == ST_CLEAR) begin
            age[idx] <= 2'd0;
        end else begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                if (obs_hit && (obs_idx == IW'(i)))
                    age[i] <= AGE_LOAD;
                else if (cycle_end && (age[i] != 2'd0))
                    age[i] <= age[i] - 2'd1;
            end
        end
    end

    always_comb begin
        claimed_vec = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) claimed_vec[i] = (age[i] != 2'd0);
    end
`else
    logic [TABLE_DEPTH-1:0] flag;
    logic                   unused_cycle_end;

    assign unused_cycle_end = cycle_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flag <= '0;
        else if (state == ST_CLEAR)
            flag[idx] <= 1'b0;
        else if (obs_hit)
            flag[obs_idx] <= 1'b1;
    end

    assign claimed_vec = flag;
`endif

    always_comb begin
        take_free    = !cur_claimed && (idx != '0) && !acc_free_vld;
        nxt_max      = cur_claimed ? 8'(idx) : acc_max;
        nxt_free     = take_free ? 8'(idx) : acc_free;
        nxt_free_vld = acc_free_vld || take_free;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            clear_done   <= 1'b0;
            scan_done    <= 1'b0;
            claiming     <= 1'b0;
            max_claim    <= 8'd0;
            free_txop    <= 8'd0;
            free_valid   <= 1'b0;
            acc_max      <= 8'd0;
            acc_free     <= 8'd0;
            acc_free_vld <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            scan_done  <= 1'b0;
            claiming   <= qry_hit && claimed_vec[claiming_id[IW-1:0]];
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state      <= ST_CLEAR;
                        idx        <= '0;
                        busy       <= 1'b1;
                        max_claim  <= 8'd0;
                        free_txop  <= 8'd0;
                        free_valid <= 1'b0;
                    end else if (scan_req) begin
                        state        <= ST_SCAN;
                        idx          <= '0;
                        busy         <= 1'b1;
                        acc_max      <= 8'd0;
                        acc_free     <= 8'd0;
                        acc_free_vld <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    idx          <= idx + 1'b1;
                    acc_max      <= nxt_max;
                    acc_free     <= nxt_free;
                    acc_free_vld <= nxt_free_vld;
                    if (idx == LAST_IDX) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        scan_done  <= 1'b1;
                        max_claim  <= nxt_max;
                        free_txop  <= nxt_free;
                        free_valid <= nxt_free_vld;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// Directed bench for dplca_txop_table_ctrl (depth 256); aging checks follow DPLCA_TXOP_AGING_EN.
module tb_dplca_txop_table_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clear_req;
    logic       clear_done;
    logic       scan_req;
    logic       scan_done;
    logic       busy;
    logic       obs_valid;
    logic [7:0] obs_id;
    logic       cycle_end;
    logic [7:0] claiming_id;
    logic       claiming;
    logic [7:0] max_claim;
    logic [7:0] free_txop;
    logic       free_valid;

    int errors = 0;
    int checks = 0;

    dplca_txop_table_ctrl #(.TABLE_DEPTH(256), .AGE_MAX(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .clear_req(clear_req), .clear_done(clear_done),
        .scan_req(scan_req), .scan_done(scan_done), .busy(busy),
        .obs_valid(obs_valid), .obs_id(obs_id), .cycle_end(cycle_end),
        .claiming_id(claiming_id), .claiming(claiming),
        .max_claim(max_claim), .free_txop(free_txop), .free_valid(free_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks are entered and left just after a falling edge.
    task automatic observe(input logic [7:0] id);
        obs_valid = 1'b1;
        obs_id    = id;
        @(negedge clk);
        obs_valid = 1'b0;
    endtask

    task automatic strobe();
        cycle_end = 1'b1;
        @(negedge clk);
        cycle_end = 1'b0;
    endtask

    // lat = cycles from acceptance edge to the done pulse; 400 means it never came.
    task automatic do_req(input bit is_clear, output int lat, output int busy_cnt);
        if (is_clear) clear_req = 1'b1; else scan_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        scan_req  = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!(is_clear ? clear_done : scan_done) && lat < 400) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat, bc;
        reset_n = 1'b0; clear_req = 1'b0; scan_req = 1'b0; obs_valid = 1'b0;
        obs_id = 8'd0; cycle_end = 1'b0; claiming_id = 8'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got=%b exp=0", clear_done); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got=%b exp=0", scan_done); end
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL reset_claiming got=%b exp=0", claiming); end
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL reset_max_claim got=%0d exp=0", max_claim); end
        checks++; if (free_txop !== 8'd0) begin errors++; $display("FAIL reset_free_txop got=%0d exp=0", free_txop); end
        checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL reset_free_valid got=%b exp=0", free_valid); end
        do_req(1'b0, lat, bc);
        checks++; if (lat !== 257) begin errors++; $display("FAIL empty_scan_latency got=%0d exp=257", lat); end
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL empty_max_claim got=%0d exp=0", max_claim); end
        checks++; if (free_txop !== 8'd1) begin errors++; $display("FAIL empty_free_txop got=%0d exp=1", free_txop); end
        checks++; if (free_valid !== 1'b1) begin errors++; $display("FAIL empty_free_valid got=%b exp=1", free_valid); end
    endtask

    task automatic test_observe_scan();
        int lat, bc;
        observe(8'd3); observe(8'd7); observe(8'd5); observe(8'd1);
        claiming_id = 8'd7;
        @(negedge clk);
        checks++; if (claiming !== 1'b1) begin errors++; $display("FAIL claiming_7 got=%b exp=1", claiming); end
        claiming_id = 8'd2;
        @(negedge clk);
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL claiming_2 got=%b exp=0", claiming); end
        do_req(1'b0, lat, bc);
        checks++; if (lat !== 257) begin errors++; $display("FAIL scan_latency got=%0d exp=257", lat); end
        checks++; if (bc !== 256) begin errors++; $display("FAIL scan_busy_cycles got=%0d exp=256", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got=%b exp=0", busy); end
        checks++; if (max_claim !== 8'd7) begin errors++; $display("FAIL obs_max_claim got=%0d exp=7", max_claim); end
        checks++; if (free_txop !== 8'd2) begin errors++; $display("FAIL obs_free_txop got=%0d exp=2", free_txop); end
        checks++; if (free_valid !== 1'b1) begin errors++; $display("FAIL obs_free_valid got=%b exp=1", free_valid); end
        @(negedge clk);
        checks++; if (max_claim !== 8'd7) begin errors++; $display("FAIL result_hold got=%0d exp=7", max_claim); end
    endtask

    task automatic test_aging();
        claiming_id = 8'd4;
        observe(8'd4);
        strobe(); strobe();
        @(negedge clk);
        checks++; if (claiming !== 1'b1) begin errors++; $display("FAIL age_after_2 got=%b exp=1", claiming); end
        strobe();
        checks++; if (claiming !== 1'b1) begin errors++; $display("FAIL age_latency got=%b exp=1", claiming); end
        @(negedge clk);
`ifdef DPLCA_TXOP_AGING_EN
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL age_after_3 got=%b exp=0", claiming); end
        observe(8'd4);
        strobe(); strobe();
        obs_valid = 1'b1; obs_id = 8'd4; cycle_end = 1'b1;
        @(negedge clk);
        obs_valid = 1'b0; cycle_end = 1'b0;
        strobe(); strobe();
        @(negedge clk);
        checks++; if (claiming !== 1'b1) begin errors++; $display("FAIL age_reload_wins got=%b exp=1", claiming); end
`else
        checks++; if (claiming !== 1'b1) begin errors++; $display("FAIL no_aging_hold got=%b exp=1", claiming); end
`endif
    endtask

    task automatic test_full_then_clear();
        int lat, bc;
        for (int i = 1; i < 256; i++) begin
            obs_valid = 1'b1;
            obs_id = 8'(i);
            @(negedge clk);
        end
        obs_valid = 1'b0;
        do_req(1'b0, lat, bc);
        checks++; if (max_claim !== 8'd255) begin errors++; $display("FAIL full_max_claim got=%0d exp=255", max_claim); end
        checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL full_free_valid got=%b exp=0", free_valid); end
        checks++; if (free_txop !== 8'd0) begin errors++; $display("FAIL full_free_txop got=%0d exp=0", free_txop); end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL clear_entry_max got=%0d exp=0", max_claim); end
        lat = 1; bc = 0;
        while (!clear_done && lat < 400) begin
            if (busy) bc++;
            obs_valid = (lat == 100);   // entry 2 already passed, must be dropped
            obs_id    = 8'd2;
            @(negedge clk);
            lat++;
        end
        obs_valid = 1'b0;
        checks++; if (lat !== 257) begin errors++; $display("FAIL clear_latency got=%0d exp=257", lat); end
        checks++; if (bc !== 256) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=256", bc); end
        claiming_id = 8'd7;
        @(negedge clk);
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL cleared_claiming_7 got=%b exp=0", claiming); end
        claiming_id = 8'd2;
        @(negedge clk);
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL clear_obs_dropped got=%b exp=0", claiming); end
        do_req(1'b0, lat, bc);
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL post_clear_max got=%0d exp=0", max_claim); end
        checks++; if (free_txop !== 8'd1) begin errors++; $display("FAIL post_clear_free got=%0d exp=1", free_txop); end
    endtask

    task automatic test_arbitration();
        int lat, bc, n;
        bit saw_scan;
        observe(8'd6);
        do_req(1'b0, lat, bc);
        checks++; if (max_claim !== 8'd6) begin errors++; $display("FAIL arb_pre_max got=%0d exp=6", max_claim); end
        clear_req = 1'b1; scan_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0; scan_req = 1'b0;
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL arb_clear_wins got=%0d exp=0", max_claim); end
        saw_scan = 1'b0;
        n = 0;
        while (!clear_done && n < 400) begin
            scan_req = (n > 50 && n < 60);
            if (scan_done) saw_scan = 1'b1;
            @(negedge clk);
            n++;
        end
        scan_req = 1'b0;
        checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL arb_clear_done got=%b exp=1", clear_done); end
        repeat (300) begin
            if (scan_done || busy) saw_scan = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_scan !== 1'b0) begin errors++; $display("FAIL arb_not_queued got=%b exp=0", saw_scan); end
    endtask

    task automatic test_back_to_back();
        int n;
        observe(8'd9);
        scan_req = 1'b1;
        @(negedge clk);
        n = 1;
        while (!scan_done && n < 400) begin @(negedge clk); n++; end
        checks++; if (n !== 257) begin errors++; $display("FAIL b2b_first got=%0d exp=257", n); end
        checks++; if (max_claim !== 8'd9) begin errors++; $display("FAIL b2b_max got=%0d exp=9", max_claim); end
        @(negedge clk);
        scan_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm got=%b exp=1", busy); end
        n = 1;
        while (!scan_done && n < 400) begin @(negedge clk); n++; end
        checks++; if (n !== 257) begin errors++; $display("FAIL b2b_second got=%0d exp=257", n); end
    endtask

    task automatic test_reset_mid_scan();
        bit saw_done;
        observe(8'd3);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (max_claim !== 8'd0) begin errors++; $display("FAIL rst_mid_max got=%0d exp=0", max_claim); end
        checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_free_valid got=%b exp=0", free_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        claiming_id = 8'd3;
        saw_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (scan_done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got=%b exp=0", saw_done); end
        checks++; if (claiming !== 1'b0) begin errors++; $display("FAIL rst_mid_claiming_3 got=%b exp=0", claiming); end
    endtask

    initial begin
        test_reset();
        test_observe_scan();
        test_aging();
        test_full_then_clear();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
